// File: rtl/sigdel_sample_ctrl.sv
// Sample FIFO and oversampling-rate divider that feed a sigma-delta DAC code register.
// Prime/run/underrun sequencing keeps the DAC at mid-scale until enough samples are buffered.
module sigdel_sample_ctrl #(
  parameter int unsigned BITLEN    = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned PRIME_LVL = 4,
  parameter int unsigned DIVW      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [DIVW-1:0]              osr_div,
  input  logic [BITLEN-1:0]            s_data,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic                         clr_underrun,
  output logic [BITLEN-1:0]            dac_code,
  output logic                         sample_tick,
  output logic                         underrun,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic [1:0]                   state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [BITLEN-1:0] MID = BITLEN'(1) << (BITLEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DIVW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic [BITLEN-1:0] dac_q, dac_d;
  logic              underrun_q, underrun_d;
  logic [BITLEN-1:0] mem_q [DEPTH];

  logic tick_c;
  logic push_c;
  logic pop_c;

  // Ready is gated by rst so no sample is accepted while reset is being applied.
  assign s_ready     = !rst && (state_q != IDLE) && (level_q < LW'(DEPTH));
  assign tick_c      = (state_q == RUN) && (cnt_q == DIVW'(0));
  assign push_c      = s_valid && s_ready && en;
  assign pop_c       = tick_c && (level_q != LW'(0));

  assign sample_tick = tick_c;
  assign dac_code    = dac_q;
  assign underrun    = underrun_q;
  assign fifo_level  = level_q;
  assign state       = state_q;

  // Next-state for FSM, divider, FIFO pointers and output registers.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    dac_d      = dac_q;
    underrun_d = underrun_q;

    if (clr_underrun) begin
      underrun_d = 1'b0;
    end

    if (!en) begin
      state_d = IDLE;
      cnt_d   = DIVW'(0);
      wptr_d  = AW'(0);
      rptr_d  = AW'(0);
      level_d = LW'(0);
      dac_d   = MID;
    end else begin
      if (push_c) begin
        wptr_d = wptr_q + AW'(1);
      end
      if (pop_c) begin
        rptr_d = rptr_q + AW'(1);
        dac_d  = mem_q[rptr_q];
      end
      if (push_c && !pop_c) begin
        level_d = level_q + LW'(1);
      end else if (!push_c && pop_c) begin
        level_d = level_q - LW'(1);
      end

      unique case (state_q)
        IDLE: begin
          state_d = PRIME;
          cnt_d   = DIVW'(0);
        end
        PRIME: begin
          if (level_q >= LW'(PRIME_LVL)) begin
            state_d = RUN;
            cnt_d   = osr_div;
          end
        end
        RUN: begin
          if (tick_c) begin
            cnt_d = osr_div;
            // Starved tick: hold the last code and re-prime the buffer.
            if (level_q == LW'(0)) begin
              underrun_d = 1'b1;
              state_d    = PRIME;
            end
          end else begin
            cnt_d = cnt_q - DIVW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = DIVW'(0);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= DIVW'(0);
      wptr_q     <= AW'(0);
      rptr_q     <= AW'(0);
      level_q    <= LW'(0);
      dac_q      <= MID;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      dac_q      <= dac_d;
      underrun_q <= underrun_d;
    end
  end

  // Sample storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wptr_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_sigdel_sample_ctrl.sv
// Directed bench for sigdel_sample_ctrl with hand-computed expectations.
module tb_sigdel_sample_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] osr_div;
  logic [15:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        clr_underrun;
  logic [15:0] dac_code;
  logic        sample_tick;
  logic        underrun;
  logic [3:0]  fifo_level;
  logic [1:0]  state;

  int checks;
  int failures;

  sigdel_sample_ctrl #(
    .BITLEN(16), .DEPTH(8), .PRIME_LVL(4), .DIVW(16)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .osr_div(osr_div),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .clr_underrun(clr_underrun), .dac_code(dac_code),
    .sample_tick(sample_tick), .underrun(underrun),
    .fifo_level(fifo_level), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1; en = 1'b0; osr_div = 16'd0; s_data = 16'd0;
    s_valid = 1'b0; clr_underrun = 1'b0;

    // Reset state
    cyc(); cyc();
    check("rst_state", 32'(state), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_dac", 32'(dac_code), 32'h8000);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_tick", 32'(sample_tick), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    cyc();
    check("post_rst_ready", 32'(s_ready), 32'd0);

    // Prime and run at osr_div=3
    en = 1'b1; osr_div = 16'd3;
    cyc();
    check("prime_state", 32'(state), 32'd1);
    check("prime_ready", 32'(s_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      s_data = 16'(16'h1000 * (i + 1)); s_valid = 1'b1;
      cyc();
    end
    s_valid = 1'b0;
    check("primed_level", 32'(fifo_level), 32'd4);
    check("primed_state", 32'(state), 32'd1);
    check("primed_dac", 32'(dac_code), 32'h8000);
    cyc();
    check("run_state", 32'(state), 32'd2);
    check("run_tick0", 32'(sample_tick), 32'd0);
    for (int c = 1; c <= 20; c++) begin
      cyc();
      if (c < 20) check("run_tick", 32'(sample_tick), 32'((c % 4) == 3));
      if ((c % 4) == 0 && c <= 16) check("run_dac", 32'(dac_code), 32'(16'h1000 * (c / 4)));
    end
    check("ur1_flag", 32'(underrun), 32'd1);
    check("ur1_state", 32'(state), 32'd1);
    check("ur1_dac", 32'(dac_code), 32'h4000);
    clr_underrun = 1'b1;
    cyc();
    clr_underrun = 1'b0;
    check("clr_underrun", 32'(underrun), 32'd0);

    // Underrun at osr_div=0, clear colliding with set
    osr_div = 16'd0;
    for (int i = 0; i < 4; i++) begin
      s_data = 16'(16'h1000 * (i + 1)); s_valid = 1'b1;
      cyc();
    end
    s_valid = 1'b0;
    cyc();
    check("ur_run_state", 32'(state), 32'd2);
    check("ur_tick_e", 32'(sample_tick), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      check("ur_dac", 32'(dac_code), 32'(16'h1000 * c));
      check("ur_tick", 32'(sample_tick), 32'd1);
    end
    check("ur_level0", 32'(fifo_level), 32'd0);
    check("ur_pre_flag", 32'(underrun), 32'd0);
    clr_underrun = 1'b1;
    cyc();
    clr_underrun = 1'b0;
    check("ur2_flag_set_wins", 32'(underrun), 32'd1);
    check("ur2_state", 32'(state), 32'd1);
    check("ur2_dac_hold", 32'(dac_code), 32'h4000);
    check("ur2_tick_prime", 32'(sample_tick), 32'd0);

    // Full and backpressure at osr_div=100
    osr_div = 16'd100;
    for (int i = 0; i < 10; i++) begin
      s_data = 16'(16'hA000 + i); s_valid = 1'b1;
      cyc();
      check("full_level", 32'(fifo_level), 32'((i + 1) > 8 ? 8 : (i + 1)));
      check("full_ready", 32'(s_ready), 32'((i + 1) < 8));
    end
    s_valid = 1'b0;
    repeat (95) cyc();
    check("full_tick", 32'(sample_tick), 32'd1);
    check("full_tick_level", 32'(fifo_level), 32'd8);
    osr_div = 16'd0;
    cyc();
    check("after_tick_level", 32'(fifo_level), 32'd7);
    check("after_tick_ready", 32'(s_ready), 32'd1);
    check("after_tick_dac", 32'(dac_code), 32'hA000);
    check("reload_new_div", 32'(sample_tick), 32'd1);
    for (int k = 1; k <= 7; k++) begin
      cyc();
      check("drain_dac", 32'(dac_code), 32'(16'hA000 + k));
    end
    check("drain_level", 32'(fifo_level), 32'd0);
    cyc();
    check("drain_ur_state", 32'(state), 32'd1);
    check("drain_ur_dac", 32'(dac_code), 32'hA007);

    // Disable in mid-RUN with 5 words buffered, push attempted same cycle
    osr_div = 16'd100;
    for (int i = 0; i < 5; i++) begin
      s_data = 16'(16'hC100 + i); s_valid = 1'b1;
      cyc();
    end
    check("dis_pre_state", 32'(state), 32'd2);
    check("dis_pre_level", 32'(fifo_level), 32'd5);
    s_data = 16'hDEAD; en = 1'b0;
    cyc();
    s_valid = 1'b0;
    check("dis_state", 32'(state), 32'd0);
    check("dis_level", 32'(fifo_level), 32'd0);
    check("dis_dac", 32'(dac_code), 32'h8000);
    check("dis_ready", 32'(s_ready), 32'd0);
    check("dis_tick", 32'(sample_tick), 32'd0);

    // Reset in mid-RUN with 3 words buffered
    en = 1'b1; osr_div = 16'd3;
    cyc();
    for (int i = 0; i < 4; i++) begin
      s_data = 16'(16'hB001 + i); s_valid = 1'b1;
      cyc();
    end
    s_valid = 1'b0;
    cyc();
    check("rr_run", 32'(state), 32'd2);
    cyc(); cyc(); cyc();
    check("rr_tick", 32'(sample_tick), 32'd1);
    cyc();
    check("rr_dac", 32'(dac_code), 32'hB001);
    check("rr_level", 32'(fifo_level), 32'd3);
    rst = 1'b1;
    cyc();
    check("rr_state", 32'(state), 32'd0);
    check("rr_level0", 32'(fifo_level), 32'd0);
    check("rr_dac_mid", 32'(dac_code), 32'h8000);
    check("rr_underrun", 32'(underrun), 32'd0);
    check("rr_tick0", 32'(sample_tick), 32'd0);
    check("rr_ready_in_rst", 32'(s_ready), 32'd0);
    rst = 1'b0;
    check("rr_ready_after", 32'(s_ready), 32'd0);
    osr_div = 16'd0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      s_data = 16'(16'hC001 + i); s_valid = 1'b1;
      cyc();
    end
    s_valid = 1'b0;
    cyc();
    check("rr2_tick", 32'(sample_tick), 32'd1);
    cyc();
    check("rr2_dac1", 32'(dac_code), 32'hC001);
    cyc();
    check("rr2_dac2", 32'(dac_code), 32'hC002);

    // Rate change 3 -> 7 between ticks
    en = 1'b0;
    cyc();
    en = 1'b1; osr_div = 16'd3;
    cyc();
    for (int i = 0; i < 4; i++) begin
      s_data = 16'(16'hD001 + i); s_valid = 1'b1;
      cyc();
    end
    s_valid = 1'b0;
    cyc();
    check("rc_run", 32'(state), 32'd2);
    for (int c = 1; c <= 16; c++) begin
      cyc();
      if (c == 4) osr_div = 16'd7;
      check("rc_tick", 32'(sample_tick), 32'(c == 3 || c == 7 || c == 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sigdel_sample_ctrl.md
SIGDEL_SAMPLE_CTRL -- requirements
Module: sigdel_sample_ctrl

Interface
REQ-001 Parameter BITLEN, default 16: width of sample words and of dac_code.
REQ-002 Parameter DEPTH, default 8: sample FIFO depth in entries; power of two, at least 2.
REQ-003 Parameter PRIME_LVL, default 4: FIFO level required to leave PRIME; range 1..DEPTH.
REQ-004 Parameter DIVW, default 16: width of osr_div.
REQ-005 clk  in  1  single clock for all logic.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 en  in  1  run enable; 0 forces IDLE.
REQ-008 osr_div  in  DIVW  sample period minus one, in clk cycles.
REQ-009 s_data  in  BITLEN  incoming unsigned sample.
REQ-010 s_valid  in  1  s_data is valid.
REQ-011 s_ready  out  1  controller can accept a sample this cycle.
REQ-012 clr_underrun  in  1  clears the sticky underrun flag.
REQ-013 dac_code  out  BITLEN  registered code driven to the sigma-delta DAC input.
REQ-014 sample_tick  out  1  one-cycle pulse at each sample instant.
REQ-015 underrun  out  1  sticky underrun flag.
REQ-016 fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-017 state  out  2  FSM state encoding: IDLE=0, PRIME=1, RUN=2.

Function
REQ-018 MID = 2**(BITLEN-1). dac_code SHALL equal MID in IDLE.
REQ-019 s_ready SHALL be high exactly when state != IDLE and fifo_level < DEPTH. It is combinational from registered state.
REQ-020 A push SHALL occur on s_valid && s_ready. s_data is written at the tail, and fifo_level increments at the next edge.
REQ-021 A pop SHALL occur only on sample_tick in RUN with fifo_level > 0. The head word is registered into dac_code at the same edge, so the new code is visible the cycle after the tick.
REQ-022 On a simultaneous push and pop, fifo_level SHALL be unchanged. A word pushed in cycle N SHALL NOT be popped in cycle N.
REQ-023 FIFO pointers SHALL wrap modulo DEPTH. Overflow is impossible because s_ready is low when full.
REQ-024 Divider: a down-counter of width DIVW. In RUN it decrements each cycle. sample_tick = (state==RUN && cnt==0). On a tick, cnt reloads from the current osr_div.
REQ-025 osr_div=0 SHALL yield a tick on every RUN cycle. A change to osr_div SHALL take effect only at the next reload.
REQ-026 IDLE -> PRIME when en=1. cnt is held at 0 in IDLE.
REQ-027 PRIME -> RUN when fifo_level >= PRIME_LVL. On that transition, cnt loads osr_div, so the first tick occurs osr_div+1 cycles after entering RUN. dac_code is held in PRIME.
REQ-028 RUN, tick with fifo_level=0: dac_code SHALL hold its last value, underrun SHALL set, and the next state SHALL be PRIME.
REQ-029 In any state, en=0 SHALL cause, at the next edge: state IDLE, FIFO flushed (pointers and level to 0), dac_code=MID, cnt=0. The en=0 action has priority over push, pop and tick.
REQ-030 underrun SHALL stay set until a cycle with clr_underrun=1. If set and clear occur in the same cycle, set wins.
REQ-031 sample_tick SHALL be 0 in IDLE and PRIME.

Reset
REQ-032 rst=1 at a clock edge SHALL force: state=IDLE, FIFO empty, fifo_level=0, cnt=0, dac_code=MID, underrun=0, sample_tick=0.
REQ-033 rst SHALL have priority over en and every other input. Reset in mid-RUN SHALL discard all FIFO contents with no pop.
REQ-034 s_ready SHALL be 0 while rst=1 and during the first cycle after reset.

Verification
REQ-035 Prime and run: rst, then en=1, osr_div=3; push 0x1000, 0x2000, 0x3000, 0x4000 back-to-back -> RUN once fifo_level=4. First tick 4 cycles after entering RUN, then every 4 cycles. dac_code = 0x1000, 0x2000, 0x3000, 0x4000, each one cycle after its tick.
REQ-036 Full and backpressure: DEPTH=8, osr_div=100, push continuously -> s_ready=0 when fifo_level=8. No data is lost or duplicated, and after one tick s_ready=1 with fifo_level=7.
REQ-037 Underrun: push 4 words at osr_div=0 with no further pushes -> 4 consecutive ticks pop all words. The 5th tick sets underrun=1, dac_code holds 0x4000, state=PRIME. clr_underrun asserted in the same cycle as a new underrun leaves underrun=1.
REQ-038 Disable in mid-RUN: en=0 with fifo_level=5 -> the next cycle shows state=IDLE, fifo_level=0, dac_code=0x8000, s_ready=0, sample_tick=0.
REQ-039 Reset in mid-RUN: rst=1 for one cycle with fifo_level=3 -> every output takes its REQ-032 value. No pop occurs, and the old data is never emitted after re-enable.
REQ-040 Rate change: osr_div changed from 3 to 7 between ticks -> the current period stays at 4 cycles, and subsequent periods are 8 cycles.
